// File: rtl/unix_time_counter.sv
// Free-running seconds counter advanced by a clock-enable prescaler, with
// synchronous load, single-cycle tick/wrap pulses and a sticky alarm flag.
module unix_time_counter #(
  parameter int N = 64,
  parameter int M = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_n,
  input  logic         go,
  input  logic [N-1:0] set_counter,
  input  logic [M-1:0] div,
  input  logic [N-1:0] alarm_value,
  input  logic         alarm_wr,
  input  logic         alarm_en,
  input  logic         alarm_clr,
  output logic [N-1:0] counter,
  output logic         tick,
  output logic         wrap,
  output logic         alarm
);

  logic [M-1:0] p_q, p_d;
  logic [N-1:0] counter_q, counter_d;
  logic [N-1:0] alarm_reg_q, alarm_reg_d;
  logic         tick_q, tick_d;
  logic         wrap_q, wrap_d;
  logic         alarm_q, alarm_d;
  logic [M-1:0] div_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    p_d         = p_q;
    counter_d   = counter_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    alarm_reg_d = alarm_wr ? alarm_value : alarm_reg_q;
    alarm_d     = alarm_q;

    // div of 0 or 1 both mean a tick on every enabled cycle; >= lets a
    // shrinking divisor fire immediately instead of waiting for p to wrap.
    div_last = (div == '0) ? '0 : div - M'(1);

    if (!load_n) begin
      counter_d = set_counter;
      p_d       = '0;
    end else if (go) begin
      if (p_q >= div_last) begin
        p_d       = '0;
        counter_d = counter_q + N'(1);
        tick_d    = 1'b1;
        wrap_d    = (counter_q == '1);
      end else begin
        p_d = p_q + M'(1);
      end
    end

    // Set beats clear; the match sees an alarm value written this same cycle.
    if (alarm_wr || alarm_clr) alarm_d = 1'b0;
    if (tick_d && alarm_en && (counter_d == alarm_reg_d)) alarm_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q         <= '0;
      counter_q   <= '0;
      alarm_reg_q <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      counter_q   <= counter_d;
      alarm_reg_q <= alarm_reg_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      alarm_q     <= alarm_d;
    end
  end

  assign counter = counter_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_unix_time_counter.sv
// Directed bench for unix_time_counter at N=8, M=4: a vector table for the
// load/wrap/alarm behaviour plus hand sequences for prescaler and reset corners.
module tb_unix_time_counter;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_n;
  logic         go;
  logic [N-1:0] set_counter;
  logic [M-1:0] div;
  logic [N-1:0] alarm_value;
  logic         alarm_wr;
  logic         alarm_en;
  logic         alarm_clr;
  logic [N-1:0] counter;
  logic         tick;
  logic         wrap;
  logic         alarm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unix_time_counter #(.N(N), .M(M)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_n      (load_n),
    .go          (go),
    .set_counter (set_counter),
    .div         (div),
    .alarm_value (alarm_value),
    .alarm_wr    (alarm_wr),
    .alarm_en    (alarm_en),
    .alarm_clr   (alarm_clr),
    .counter     (counter),
    .tick        (tick),
    .wrap        (wrap),
    .alarm       (alarm)
  );

  typedef struct {
    logic         load_n;
    logic         go;
    logic [N-1:0] set_counter;
    logic [M-1:0] div;
    logic [N-1:0] alarm_value;
    logic         alarm_wr;
    logic         alarm_en;
    logic         alarm_clr;
    logic [N-1:0] exp_counter;
    logic         exp_tick;
    logic         exp_wrap;
    logic         exp_alarm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic g, logic [N-1:0] sc, logic [M-1:0] dv,
                              logic [N-1:0] av, logic aw, logic ae, logic ac,
                              logic [N-1:0] ec, logic et, logic ew, logic ea);
    vec_t v;
    v.load_n = ld; v.go = g; v.set_counter = sc; v.div = dv;
    v.alarm_value = av; v.alarm_wr = aw; v.alarm_en = ae; v.alarm_clr = ac;
    v.exp_counter = ec; v.exp_tick = et; v.exp_wrap = ew; v.exp_alarm = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [N-1:0] ec, input logic et,
                           input logic ew, input logic ea);
    check({name, ".counter"}, 64'(counter), 64'(ec));
    check({name, ".tick"},    64'(tick),    64'(et));
    check({name, ".wrap"},    64'(wrap),    64'(ew));
    check({name, ".alarm"},   64'(alarm),   64'(ea));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_n = 1'b1; go = 1'b0; set_counter = '0; div = '0;
    alarm_value = '0; alarm_wr = 1'b0; alarm_en = 1'b0; alarm_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    // Vectors start from counter=0x04, p=0, alarm register=0, alarm=0.
    vecs.push_back(mk(0,1,8'hFE,1, 8'h00,0,0,0, 8'hFE,0,0,0));
    vecs.push_back(mk(1,1,8'h00,1, 8'h00,0,0,0, 8'hFF,1,0,0));
    vecs.push_back(mk(1,1,8'h00,1, 8'h00,0,0,0, 8'h00,1,1,0));
    vecs.push_back(mk(1,1,8'h00,1, 8'h00,0,0,0, 8'h01,1,0,0));
    vecs.push_back(mk(1,0,8'h00,2, 8'h03,1,1,0, 8'h01,0,0,0));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h01,0,0,0));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h02,1,0,0));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h02,0,0,0));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h03,1,0,1));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h03,0,0,1));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h04,1,0,1));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,1, 8'h04,0,0,0));
    vecs.push_back(mk(1,1,8'h00,2, 8'h00,0,1,0, 8'h05,1,0,0));
    vecs.push_back(mk(0,1,8'h03,2, 8'h00,0,1,0, 8'h03,0,0,0));
    vecs.push_back(mk(0,1,8'hFE,0, 8'h00,0,1,0, 8'hFE,0,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,0, 8'hFF,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,0, 8'h00,1,1,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,0, 8'h01,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,0, 8'h02,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,0, 8'h03,1,0,1));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,0,1, 8'h04,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,0,0, 8'h05,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h06,1,1,0, 8'h06,1,0,1));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,1,1, 8'h07,1,0,0));
    vecs.push_back(mk(1,1,8'h00,0, 8'h08,1,1,1, 8'h08,1,0,1));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,0,0, 8'h09,1,0,1));
    vecs.push_back(mk(1,1,8'h00,0, 8'h00,0,0,0, 8'h0A,1,0,1));
    vecs.push_back(mk(1,0,8'h00,0, 8'h00,0,0,1, 8'h0A,0,0,0));

    // Reset state
    #12;
    check_all("reset", 8'h00, 0, 0, 0);
    #2 reset_n = 1'b1;
    step();

    // div=5 from reset: one tick every 5 enabled cycles
    div = 4'd5; go = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check_all($sformatf("div5[%0d]", i), N'(i / 5), (i % 5) == 0, 0, 0);
    end
    go = 1'b0;

    // div=4 with a 7-cycle go=0 gap after two enabled cycles
    div = 4'd4;
    for (int i = 1; i <= 11; i++) begin
      go = (i >= 3 && i <= 9) ? 1'b0 : 1'b1;
      step();
      check_all($sformatf("freeze[%0d]", i), (i == 11) ? 8'h04 : 8'h03, i == 11, 0, 0);
    end
    idle_inputs();

    foreach (vecs[i]) begin
      load_n = vecs[i].load_n; go = vecs[i].go; set_counter = vecs[i].set_counter;
      div = vecs[i].div; alarm_value = vecs[i].alarm_value; alarm_wr = vecs[i].alarm_wr;
      alarm_en = vecs[i].alarm_en; alarm_clr = vecs[i].alarm_clr;
      step();
      check_all($sformatf("vec[%0d]", i), vecs[i].exp_counter, vecs[i].exp_tick,
                vecs[i].exp_wrap, vecs[i].exp_alarm);
    end
    idle_inputs();

    // div 9 -> 2 with p=6 ticks on the next enabled cycle; then div=0
    div = 4'd9; go = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_all($sformatf("div9[%0d]", i), 8'h0A, 0, 0, 0);
    end
    div = 4'd2;
    step(); check_all("div2_now", 8'h0B, 1, 0, 0);
    step(); check_all("div2_p1",  8'h0B, 0, 0, 0);
    step(); check_all("div2_tk",  8'h0C, 1, 0, 0);
    div = 4'd0;
    step(); check_all("div0_a",   8'h0D, 1, 0, 0);
    step(); check_all("div0_b",   8'h0E, 1, 0, 0);
    idle_inputs();

    // Async reset while counter=0x2A with tick and alarm high
    load_n = 1'b0; set_counter = 8'h29; alarm_wr = 1'b1; alarm_value = 8'h2A; alarm_en = 1'b1;
    step(); check_all("pre_rst_ld", 8'h29, 0, 0, 0);
    load_n = 1'b1; alarm_wr = 1'b0; div = 4'd1; go = 1'b1;
    step(); check_all("pre_rst_tk", 8'h2A, 1, 0, 1);
    go = 1'b0;
    #3 reset_n = 1'b0;
    #1 check_all("async_rst", 8'h00, 0, 0, 0);
    @(posedge clk);
    #4 reset_n = 1'b1;

    // Reset mid-count discards prescaler progress
    div = 4'd4; go = 1'b1;
    step(); step();
    check_all("pre_rst2", 8'h00, 0, 0, 0);
    #3 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all($sformatf("post_rst[%0d]", i), (i == 4) ? 8'h01 : 8'h00, i == 4, 0, 0);
    end

    // Load wins over tick and suppresses tick/wrap
    div = 4'd0; go = 1'b1; load_n = 1'b0; set_counter = 8'h55;
    step(); check_all("ld_vs_tick", 8'h55, 0, 0, 0);
    go = 1'b0; set_counter = 8'hFF;
    step(); check_all("ld_go0", 8'hFF, 0, 0, 0);
    go = 1'b1; set_counter = 8'h77;
    step(); check_all("ld_at_ff", 8'h77, 0, 0, 0);
    load_n = 1'b1;
    step(); check_all("after_ld", 8'h78, 1, 0, 0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
